// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: state encoding, instruction
// bit positions and array geometry.
package core_ctrl_pkg;

    localparam int COL   = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;   // SRAM address width
    localparam int CW    = 5;   // counter width: must reach DEPTH (EXEC runs nq+1 cycles)

    localparam int INST_W = 17;

    // Instruction word bit positions
    localparam int INST_OFIFO_RD  = 16;
    localparam int INST_QK_ADD_LO = 12;   // [15:12]
    localparam int INST_P_ADD_LO  = 8;    // [11:8]
    localparam int INST_EXECUTE   = 7;
    localparam int INST_KLOAD     = 6;
    localparam int INST_QMEM_RD   = 5;
    localparam int INST_QMEM_WR   = 4;
    localparam int INST_KMEM_RD   = 3;
    localparam int INST_KMEM_WR   = 2;
    localparam int INST_PMEM_RD   = 1;
    localparam int INST_PMEM_WR   = 0;

    // Counter slots shared by the controller
    localparam int CNT_LD = 0;   // external load word index
    localparam int CNT_RD = 1;   // KLOAD / EXEC / GAP cycle index
    localparam int CNT_DR = 2;   // drain write index
    localparam int NCNT   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_Q  = 3'd1,
        LD_K  = 3'd2,
        KLOAD = 3'd3,
        EXEC  = 3'd4,
        GAP   = 3'd5,
        DRAIN = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/core_ctrl_cnt.sv
// Up-counter with synchronous clear (load to zero), increment enable and a
// terminal-count flag against a run-time last value. The address output
// is the count modulo 2**AW.
module ctrl_cnt
    import core_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] last,
    output logic [AW-1:0] addr,
    output logic          tc
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign addr = count_q[AW-1:0];
    assign tc   = (count_q == last);

endmodule

// File: rtl/core_ctrl.sv
// Job sequencer for the attention core: loads Q and K words from the
// external bus, pushes K into the array, streams Q through it, waits for
// the array to drain and copies output FIFO rows into PSUM memory.
// Strobes and status are a register stage behind the state that produced
// them; ext_ready alone is aligned with the state so the handshake the
// source sees is exactly the one the counters see.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int col   = COL,
    parameter int depth = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        num_q,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              fifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [CW-1:0] COL_L    = CW'(col);
    localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] DEPTH_L  = CW'(depth);

    state_t              state_q, state_d;
    logic [CW-1:0]       nq_q, nq_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                ext_ready_q, ext_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;

    logic [NCNT-1:0]          cnt_clr;
    logic [NCNT-1:0]          cnt_inc;
    logic [NCNT-1:0]          cnt_tc;
    logic [NCNT-1:0][CW-1:0]  cnt_last;
    logic [NCNT-1:0][AW-1:0]  cnt_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            ctrl_cnt u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (cnt_clr[gi]),
                .inc   (cnt_inc[gi]),
                .last  (cnt_last[gi]),
                .addr  (cnt_addr[gi]),
                .tc    (cnt_tc[gi])
            );
        end
    endgenerate

    // Terminal values per state, kept apart from the FSM so tc has no loop
    always_comb begin
        cnt_last[CNT_LD] = (state_q == LD_K) ? COL_LAST : (nq_q - CW'(1));
        cnt_last[CNT_DR] = nq_q - CW'(1);
        case (state_q)
            EXEC:    cnt_last[CNT_RD] = nq_q;
            GAP:     cnt_last[CNT_RD] = COL_LAST;
            default: cnt_last[CNT_RD] = COL_L;
        endcase
    end

    // Next state, counter control and the instruction for this cycle
    always_comb begin
        state_d = state_q;
        nq_d    = nq_q;
        inst_d  = '0;
        cnt_clr = '0;
        cnt_inc = '0;
        accept  = ext_valid && ext_ready_q;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    nq_d    = (num_q > DEPTH_L) ? DEPTH_L : num_q;
                    cnt_clr = '1;
                    state_d = (num_q == '0) ? DONE : LD_Q;
                end
            end
            LD_Q: begin
                if (accept) begin
                    inst_d[INST_QMEM_WR] = 1'b1;
                    inst_d[INST_QK_ADD_LO +: AW] = cnt_addr[CNT_LD];
                    if (cnt_tc[CNT_LD]) begin
                        cnt_clr[CNT_LD] = 1'b1;
                        state_d = LD_K;
                    end else begin
                        cnt_inc[CNT_LD] = 1'b1;
                    end
                end
            end
            LD_K: begin
                if (accept) begin
                    inst_d[INST_KMEM_WR] = 1'b1;
                    inst_d[INST_QK_ADD_LO +: AW] = cnt_addr[CNT_LD];
                    if (cnt_tc[CNT_LD]) begin
                        cnt_clr[CNT_LD] = 1'b1;
                        cnt_clr[CNT_RD] = 1'b1;
                        state_d = KLOAD;
                    end else begin
                        cnt_inc[CNT_LD] = 1'b1;
                    end
                end
            end
            KLOAD: begin
                inst_d[INST_KLOAD] = 1'b1;
                if (cnt_tc[CNT_RD]) begin
                    cnt_clr[CNT_RD] = 1'b1;
                    state_d = EXEC;
                end else begin
                    inst_d[INST_KMEM_RD] = 1'b1;
                    inst_d[INST_QK_ADD_LO +: AW] = cnt_addr[CNT_RD];
                    cnt_inc[CNT_RD] = 1'b1;
                end
            end
            EXEC: begin
                inst_d[INST_EXECUTE] = 1'b1;
                if (cnt_tc[CNT_RD]) begin
                    cnt_clr[CNT_RD] = 1'b1;
                    state_d = GAP;
                end else begin
                    inst_d[INST_QMEM_RD] = 1'b1;
                    inst_d[INST_QK_ADD_LO +: AW] = cnt_addr[CNT_RD];
                    cnt_inc[CNT_RD] = 1'b1;
                end
            end
            GAP: begin
                if (cnt_tc[CNT_RD]) begin
                    cnt_clr[CNT_RD] = 1'b1;
                    cnt_clr[CNT_DR] = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_inc[CNT_RD] = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_valid) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    inst_d[INST_PMEM_WR]  = 1'b1;
                    inst_d[INST_P_ADD_LO +: AW] = cnt_addr[CNT_DR];
                    if (cnt_tc[CNT_DR]) begin
                        state_d = DONE;
                    end else begin
                        cnt_inc[CNT_DR] = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The controller never reads PSUM memory back
        inst_d[INST_PMEM_RD] = 1'b0;

        ext_ready_d = (state_d == LD_Q) || (state_d == LD_K);
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
    end

    // State, job length and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            nq_q        <= '0;
            inst_q      <= '0;
            ext_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nq_q        <= nq_d;
            inst_q      <= inst_d;
            ext_ready_q <= ext_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst      = inst_q;
    assign ext_ready = ext_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter col, default 8: number of kernel (K) rows loaded into the array per job.
REQ-002 SHALL have parameter depth, default 16: Q/K/PSUM SRAM word count; addresses are 4 bits.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle job request.
REQ-006 SHALL have port num_q  input  5  Q row count; sampled when start is accepted.
REQ-007 SHALL have port ext_valid  input  1  external data word present on the memory input bus.
REQ-008 SHALL have port ext_ready  output  1  controller accepts an external word this cycle.
REQ-009 SHALL have port fifo_valid  input  1  output FIFO holds a complete row.
REQ-010 SHALL have port inst  output  17  core instruction word.
REQ-011 SHALL have port busy  output  1  a job is in progress.
REQ-012 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-013 SHALL encode inst as follows:
- [16] ofifo_rd
- [15:12] qkmem_add
- [11:8] pmem_add
- [7] execute
- [6] kernel-load / kmem select
- [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
REQ-014 SHALL implement states IDLE, LD_Q, LD_K, KLOAD, EXEC, GAP, DRAIN, DONE; all inst bits SHALL be 0 in IDLE, GAP and DONE.
REQ-015 IDLE: start=1 with busy=0 SHALL latch nq = min(num_q,16) and enter LD_Q; if num_q=0 the block SHALL go directly to DONE instead.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 LD_Q: ext_ready=1; each ext_valid&&ext_ready cycle SHALL assert qmem_wr with qkmem_add = word index, starting at 0; after nq writes the block SHALL enter LD_K.
REQ-018 LD_K: same handshake with kmem_wr; col words at addresses 0..col-1, then enter KLOAD.
REQ-019 ext_ready SHALL be 0 outside LD_Q/LD_K.
REQ-020 An ext_valid=0 cycle SHALL stall the load with no write and no address advance.
REQ-021 KLOAD SHALL last col+1 cycles:
- inst[6]=1 in every KLOAD cycle
- kmem_rd=1 with addresses 0..col-1 in the first col cycles
- then enter EXEC.
REQ-022 EXEC SHALL last nq+1 cycles:
- inst[7]=1 in every EXEC cycle
- qmem_rd=1 with addresses 0..nq-1 in the first nq cycles
- then enter GAP.
REQ-023 GAP SHALL hold for exactly col cycles (array drain latency), then enter DRAIN.
REQ-024 DRAIN: in each cycle with fifo_valid=1, ofifo_rd and pmem_wr SHALL both be 1 with pmem_add = drain count, starting at 0; fifo_valid=0 SHALL give no read and no count advance.
REQ-025 After nq drain writes the block SHALL enter DONE.
REQ-026 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE; it SHALL be 1 during the DONE cycle.
REQ-028 Reads and writes to the same SRAM SHALL never be asserted together; qmem_* and kmem_* strobes SHALL never be asserted together.
REQ-029 Address counters SHALL wrap modulo 16; with nq=16 the last address SHALL be 15 and no wrap SHALL be observable.
REQ-030 All outputs SHALL be registered; the decision on each state's last cycle SHALL be based on counters, with no extra dead cycle.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, all counters 0, inst=0, ext_ready=0, busy=0, done=0.
REQ-032 Reset asserted mid-job SHALL abandon the job; after release the block SHALL wait for a new start.

Structure
REQ-033 A shared package SHALL hold:
- the state enumeration
- inst bit-position constants
- constants COL=8 and DEPTH=16
REQ-034 One sub-module, ctrl_cnt (a loadable up-counter with terminal-count flag), SHALL be instantiated for the load, read and drain counters.

Verification
REQ-035 Full job, start with num_q=16, ext_valid held 1, fifo_valid held 1 -> exactly:
- 16 qmem_wr at addresses 0..15, then 8 kmem_wr
- 9 KLOAD cycles, 17 EXEC cycles, 8 GAP cycles
- 16 pmem_wr at pmem_add 0..15
- then one done pulse.
REQ-036 Backpressure, num_q=3 with ext_valid toggling 1,0,1,0,... -> only 3 qmem_wr and 8 kmem_wr; addresses contiguous; no write on ext_valid=0 cycles.
REQ-037 num_q=0 -> done pulses two cycles after start, with no SRAM strobe; num_q=20 -> behaves as 16.
REQ-038 start pulsed during EXEC -> ignored; the job completes with the original nq.
REQ-039 reset driven low during DRAIN after 2 writes -> all outputs 0 immediately; a following start with num_q=2 runs a clean full job.
REQ-040 DRAIN with fifo_valid pattern 0,0,1,0,1 and nq=2 -> pmem_wr on the 3rd and 5th cycles only, at addresses 0 and 1.
